// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: FIFO-buffered command issuer for alu_top with in-order response port.
// Defining ALU_ISSUE_STATS_EN adds the saturating op_count output.
module alu_cmd_issuer #(
  parameter int N = 4,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [N-1:0]   cmd_op1,
  input  logic [N-1:0]   cmd_op2,
  input  logic [3:0]     cmd_sel,
  output logic [N-1:0]   alu_operand1,
  output logic [N-1:0]   alu_operand2,
  output logic [3:0]     alu_select,
  input  logic [2*N-1:0] alu_result,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*N-1:0] rsp_result,
  output logic [3:0]     rsp_sel,
  output logic           busy
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]    op_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;
  state_t state;
  logic [N-1:0] mem_op1 [DEPTH];
  logic [N-1:0] mem_op2 [DEPTH];
  logic [3:0] mem_sel [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic push, pop, done;
  assign cmd_ready = count != CW'(DEPTH);
  assign push = cmd_valid && cmd_ready;
  assign done = state == RESP && rsp_valid && rsp_ready;
  // A new command issues from IDLE or straight after a consumed response.
  assign pop = count != '0 && (state == IDLE || done);
  assign busy = state != IDLE || count != '0;
  always_ff @(posedge clk) begin
    if (push) begin
      mem_op1[wr_ptr] <= cmd_op1;
      mem_op2[wr_ptr] <= cmd_op2;
      mem_sel[wr_ptr] <= cmd_sel;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      alu_select <= '0;
      rsp_valid <= 1'b0;
      rsp_result <= '0;
      rsp_sel <= '0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        alu_operand1 <= mem_op1[rd_ptr];
        alu_operand2 <= mem_op2[rd_ptr];
        alu_select <= mem_sel[rd_ptr];
      end
      case (state)
        IDLE: if (pop) state <= EXEC;
        EXEC: state <= CAPT;
        CAPT: begin
          rsp_result <= alu_result;
          rsp_sel <= alu_select;
          rsp_valid <= 1'b1;
          state <= RESP;
        end
        RESP: if (done) begin
          rsp_valid <= 1'b0;
          state <= pop ? EXEC : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef ALU_ISSUE_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) op_count <= '0;
    else if (done && op_count != 16'hFFFF) op_count <= op_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed self-checking bench with a registered-multiply alu_top stub.
module tb_alu_cmd_issuer;
  logic clk = 1'b0;
  logic reset, cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
  logic [3:0] cmd_op1, cmd_op2, cmd_sel, alu_operand1, alu_operand2, alu_select, rsp_sel;
  logic [7:0] alu_result, rsp_result;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] op_count;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) alu_result <= '0;
    else alu_result <= 8'(alu_operand1) * 8'(alu_operand2);
  end
  alu_cmd_issuer #(.N(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_sel(cmd_sel),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .alu_select(alu_select),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_sel(rsp_sel), .busy(busy)
`ifdef ALU_ISSUE_STATS_EN
    , .op_count(op_count)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
    cmd_valid = v;
    cmd_op1 = a;
    cmd_op2 = b;
    cmd_sel = s;
  endtask
  logic [3:0] bp_a [6] = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11};
  logic [3:0] bp_b [6] = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12};
  logic [7:0] bp_r [5] = '{8'd2, 8'd12, 8'd30, 8'd56, 8'd90};
  initial begin
    int got, idx, last;
    logic rdy_prev;
    reset = 1'b0;
    rsp_ready = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 4'd0);
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_operand1", 32'(alu_operand1), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_result", 32'(rsp_result), 0);
`ifdef ALU_ISSUE_STATS_EN
    chk("rst_op_count", 32'(op_count), 0);
`endif
    reset = 1'b1;
    @(negedge clk);
    // single command: push at edge k, response visible after edge k+3
    rsp_ready = 1'b1;
    drive(1'b1, 4'd3, 4'd5, 4'h2);
    @(negedge clk);
    drive(1'b0, 4'd0, 4'd0, 4'd0);
    chk("single_busy_k", 32'(busy), 1);
    chk("single_valid_k", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("single_op1", 32'(alu_operand1), 3);
    chk("single_op2", 32'(alu_operand2), 5);
    chk("single_sel", 32'(alu_select), 2);
    @(negedge clk);
    chk("single_valid_k2", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("single_valid_k3", 32'(rsp_valid), 1);
    chk("single_result", 32'(rsp_result), 15);
    chk("single_rsp_sel", 32'(rsp_sel), 2);
    @(negedge clk);
    chk("single_pulse_end", 32'(rsp_valid), 0);
    chk("single_busy_end", 32'(busy), 0);
    chk("single_op1_hold", 32'(alu_operand1), 3);
    // backpressure: six offers, one cycle each; the sixth meets a full FIFO
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, bp_a[i], bp_b[i], 4'(2 * i + 1));
      if (i == 5) chk("bp_ready_full", 32'(cmd_ready), 0);
      @(negedge clk);
    end
    drive(1'b0, 4'd0, 4'd0, 4'd0);
    chk("bp_ready_after", 32'(cmd_ready), 0);
    chk("bp_busy", 32'(busy), 1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_stall_valid", 32'(rsp_valid), 1);
      chk("bp_stall_result", 32'(rsp_result), 2);
      chk("bp_stall_sel", 32'(rsp_sel), 1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      if (rsp_valid) begin
        chk("bp_result", 32'(rsp_result), 32'(bp_r[got]));
        chk("bp_sel", 32'(rsp_sel), 32'(2 * got + 1));
        got++;
      end
      @(negedge clk);
    end
    chk("bp_count", 32'(got), 5);
    repeat (2) @(negedge clk);
    chk("bp_idle", 32'(busy), 0);
    // throughput: eight commands fed as fast as cmd_ready allows
    got = 0;
    idx = 0;
    last = 0;
    rdy_prev = 1'b0;
    for (int c = 0; c < 80 && got < 8; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        chk("tp_result", 32'(rsp_result), 32'((got + 1) * (got + 2)));
        chk("tp_sel", 32'(rsp_sel), 32'(got));
        if (got > 0) chk("tp_interval", 32'(c - last), 3);
        last = c;
        got++;
      end
      if (cmd_valid && rdy_prev) idx++;
      drive(idx < 8, 4'(idx + 1), 4'(idx + 2), 4'(idx));
      rdy_prev = cmd_ready;
    end
    drive(1'b0, 4'd0, 4'd0, 4'd0);
    chk("tp_count", 32'(got), 8);
    repeat (2) @(negedge clk);
    chk("tp_idle", 32'(busy), 0);
`ifdef ALU_ISSUE_STATS_EN
    chk("stats_count", 32'(op_count), 14);
`endif
    // reset while in CAPT with two commands queued
    drive(1'b1, 4'd2, 4'd3, 4'd4);
    @(negedge clk);
    drive(1'b1, 4'd4, 4'd4, 4'd5);
    @(negedge clk);
    drive(1'b1, 4'd5, 4'd5, 4'd6);
    @(negedge clk);
    drive(1'b0, 4'd0, 4'd0, 4'd0);
    chk("mid_busy_before", 32'(busy), 1);
    reset = 1'b0;
    #1;
    chk("mid_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_cmd_ready", 32'(cmd_ready), 1);
    chk("mid_operand1", 32'(alu_operand1), 0);
`ifdef ALU_ISSUE_STATS_EN
    chk("stats_reset", 32'(op_count), 0);
`endif
    repeat (2) begin
      @(negedge clk);
      chk("mid_hold_valid", 32'(rsp_valid), 0);
    end
    reset = 1'b1;
    drive(1'b1, 4'd15, 4'd15, 4'd3);
    @(negedge clk);
    drive(1'b0, 4'd0, 4'd0, 4'd0);
    chk("post_valid_k", 32'(rsp_valid), 0);
    repeat (2) @(negedge clk);
    chk("post_valid_k2", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("post_valid_k3", 32'(rsp_valid), 1);
    chk("post_result", 32'(rsp_result), 225);
    chk("post_sel", 32'(rsp_sel), 3);
    @(negedge clk);
    chk("post_valid_end", 32'(rsp_valid), 0);
    chk("post_busy_end", 32'(busy), 0);
`ifdef ALU_ISSUE_STATS_EN
    chk("stats_post", 32'(op_count), 1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
